// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing the data port of the word-addressed memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: requester 0 wins ties).
module mem_port_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_save,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             grant_id_s;
    logic             load_cmd_s;
    logic             cmd_id_r;
    logic             cmd_id_d_s;
    logic             cmd_we_r;
    logic             cmd_we_d_s;
    logic [WIDTH-1:0] cmd_addr_r;
    logic [WIDTH-1:0] cmd_addr_d_s;
    logic [WIDTH-1:0] cmd_wdata_r;
    logic [WIDTH-1:0] cmd_wdata_d_s;
    logic             ack0_r;
    logic             ack1_r;
    logic             busy_r;
    logic             mem_save_r;
    logic [WIDTH-1:0] rdata0_r;
    logic [WIDTH-1:0] rdata1_r;
    logic             unused_addr_lsb_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic             last_winner_r;
`endif

    // Winner selection when the sequencer samples requests
    always_comb begin
        grant_id_s = 1'b0;
        if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_id_s = ~last_winner_r;
`else
            grant_id_s = 1'b0;
`endif
        end else if (req1) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_next_s = state_r;
        load_cmd_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    load_cmd_s   = 1'b1;
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_next_s = ST_RESP;
            ST_RESP:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Command register input mux: capture the winner, otherwise hold
    always_comb begin
        cmd_id_d_s    = cmd_id_r;
        cmd_we_d_s    = cmd_we_r;
        cmd_addr_d_s  = cmd_addr_r;
        cmd_wdata_d_s = cmd_wdata_r;
        if (load_cmd_s) begin
            cmd_id_d_s    = grant_id_s;
            cmd_we_d_s    = grant_id_s ? we1    : we0;
            cmd_addr_d_s  = grant_id_s ? addr1  : addr0;
            cmd_wdata_d_s = grant_id_s ? wdata1 : wdata0;
        end else begin
            cmd_id_d_s    = cmd_id_r;
            cmd_we_d_s    = cmd_we_r;
            cmd_addr_d_s  = cmd_addr_r;
            cmd_wdata_d_s = cmd_wdata_r;
        end
    end

    // State, command, strobe and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cmd_id_r    <= 1'b0;
            cmd_we_r    <= 1'b0;
            cmd_addr_r  <= {WIDTH{1'b0}};
            cmd_wdata_r <= {WIDTH{1'b0}};
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            busy_r      <= 1'b0;
            mem_save_r  <= 1'b0;
            rdata0_r    <= {WIDTH{1'b0}};
            rdata1_r    <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_next_s;
            cmd_id_r    <= cmd_id_d_s;
            cmd_we_r    <= cmd_we_d_s;
            cmd_addr_r  <= cmd_addr_d_s;
            cmd_wdata_r <= cmd_wdata_d_s;
            // Outputs are registered from the state being entered so they line up with it
            ack0_r      <= (state_next_s == ST_RESP) && !cmd_id_r;
            ack1_r      <= (state_next_s == ST_RESP) && cmd_id_r;
            busy_r      <= (state_next_s != ST_IDLE);
            mem_save_r  <= (state_next_s == ST_ACCESS) && cmd_we_d_s;
            if ((state_r == ST_RESP) && !cmd_we_r && !cmd_id_r) begin
                rdata0_r <= mem_rdata;
            end
            if ((state_r == ST_RESP) && !cmd_we_r && cmd_id_r) begin
                rdata1_r <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last-winner tracking; reset value 1 makes requester 0 win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_r <= 1'b1;
        end else if (load_cmd_s) begin
            last_winner_r <= grant_id_s;
        end else begin
            last_winner_r <= last_winner_r;
        end
    end
`endif

    // Memory is word addressed, so the byte-address LSB is dropped
    assign unused_addr_lsb_s = cmd_addr_r[0];
    assign mem_addr          = {1'b0, cmd_addr_r[WIDTH-1:1]};
    assign mem_wdata         = cmd_wdata_r;
    assign mem_save          = mem_save_r;
    assign ack0              = ack0_r;
    assign ack1              = ack1_r;
    assign busy              = busy_r;
    assign rdata0            = rdata0_r;
    assign rdata1            = rdata1_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (grant time, winner, shadow memory).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rq;
    logic [1:0]  rwe;
    logic [15:0] raddr [2];
    logic [15:0] rwd [2];
    logic        ack0, ack1, mem_save, busy;
    logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] mem_array [0:65535];
    logic        pre_en;
    logic [15:0] pre_addr, pre_data;
    logic [15:0] ref_mem [0:15];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0(rq[0]), .req1(rq[1]), .we0(rwe[0]), .we1(rwe[1]),
        .addr0(raddr[0]), .addr1(raddr[1]), .wdata0(rwd[0]), .wdata1(rwd[1]),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_save(mem_save),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory data port: synchronous write, registered read with one cycle latency
    always @(posedge clk) begin
        if (pre_en) mem_array[pre_addr] <= pre_data;
        else if (mem_save) mem_array[mem_addr] <= mem_wdata;
        mem_rdata <= mem_array[mem_addr];
    end

    task automatic do_reset();
        rst = 1'b1; rq = 2'b00; rwe = 2'b00; pre_en = 1'b0;
        raddr[0] = 16'h0; raddr[1] = 16'h0; rwd[0] = 16'h0; rwd[1] = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic new_req(input int r);
        rq[r]    = 1'b1;
        rwe[r]   = 1'($urandom);
        raddr[r] = 16'($urandom_range(0, 31));
        rwd[r]   = 16'($urandom);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({ack0, ack1, busy, mem_save} !== 4'b0000)
            $display("FAIL reset_ctrl: ack0/ack1/busy/save=%b expected 0000", {ack0, ack1, busy, mem_save});
        n_tests++;
        if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000)
            $display("FAIL reset_bus: mem_addr=%h mem_wdata=%h expected 0000/0000", mem_addr, mem_wdata);
        n_tests++;
        if (rdata0 !== 16'h0000 || rdata1 !== 16'h0000)
            $display("FAIL reset_rdata: rdata0=%h rdata1=%h expected 0000/0000", rdata0, rdata1);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", busy);
        n_fail += ((ack0 | ack1 | busy | mem_save) !== 1'b0) ? 1 : 0;
        n_fail += (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) ? 1 : 0;
        n_fail += (rdata0 !== 16'h0000 || rdata1 !== 16'h0000) ? 1 : 0;
    endtask

    task automatic test_single_read();
        preload(16'h0012, 16'hBEEF);
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 16'h0024;
        @(negedge clk);
        n_tests++;
        if (mem_addr !== 16'h0012 || mem_save !== 1'b0 || busy !== 1'b1 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_access: addr=%h save=%b busy=%b ack1=%b expected 0012/0/1/0", mem_addr, mem_save, busy, ack1);
        end
        @(negedge clk);
        n_tests++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || mem_save !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_ack: ack0=%b ack1=%b save=%b expected 1/0/0", ack0, ack1, mem_save);
        end
        rq[0] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rdata0 !== 16'hBEEF || ack0 !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_data: rdata0=%h ack0=%b busy=%b expected beef/0/0", rdata0, ack0, busy);
        end
    endtask

    task automatic test_write_read();
        rq[1] = 1'b1; rwe[1] = 1'b1; raddr[1] = 16'h0041; rwd[1] = 16'h1234;
        @(negedge clk);
        n_tests++;
        if (mem_save !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL write_access: save=%b addr=%h wdata=%h expected 1/0020/1234", mem_save, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_tests++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || mem_save !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ack: ack1=%b ack0=%b save=%b expected 1/0/0", ack1, ack0, mem_save);
        end
        rq[1] = 1'b0; rwe[1] = 1'b0;
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 16'h0040;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || mem_save !== 1'b0 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL write_idle: busy=%b save=%b ack1=%b expected 0/0/0", busy, mem_save, ack1);
        end
        @(negedge clk);
        n_tests++;
        if (mem_addr !== 16'h0020 || mem_save !== 1'b0) begin
            n_fail++;
            $display("FAIL read_back_access: addr=%h save=%b expected 0020/0", mem_addr, mem_save);
        end
        @(negedge clk);
        n_tests++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL read_back_ack: ack0=%b ack1=%b expected 1/0", ack0, ack1);
        end
        rq[0] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rdata0 !== 16'h1234 || rdata1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL read_back_data: rdata0=%h rdata1=%h expected 1234/0000", rdata0, rdata1);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_ids;
        int got = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_ids = 4'b1010;
`else
        exp_ids = 4'b0000;
`endif
        do_reset();
        rq = 2'b11; rwe = 2'b00; raddr[0] = 16'h0024; raddr[1] = 16'h0040;
        for (int cyc = 1; cyc <= 16 && got < 4; cyc++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                n_tests++;
                if ((ack0 && ack1) || ack1 !== exp_ids[got] || cyc != 2 + 3 * got) begin
                    n_fail++;
                    $display("FAIL simultaneous_ack%0d: ack0=%b ack1=%b cycle=%0d expected id=%b cycle=%0d",
                             got, ack0, ack1, cyc, exp_ids[got], 2 + 3 * got);
                end
                got++;
            end
        end
        rq = 2'b00;
        n_tests++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL simultaneous_count: acks=%0d expected 4", got);
        end
        @(negedge clk);
    endtask

    task automatic test_held();
        do_reset();
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 16'h0024;
        for (int cyc = 0; cyc < 9; cyc++) begin
            n_tests++;
            if (ack0 !== (cyc % 3 == 2) || busy !== (cyc % 3 != 0) || ack1 !== 1'b0) begin
                n_fail++;
                $display("FAIL held_cycle%0d: ack0=%b busy=%b ack1=%b expected %b/%b/0",
                         cyc, ack0, busy, ack1, (cyc % 3 == 2), (cyc % 3 != 0));
            end
            @(negedge clk);
        end
        rq[0] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL held_release: busy=%b ack0=%b expected 0/0", busy, ack0);
        end
    endtask

    task automatic test_reset_access();
        rq[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 16'h0010; rwd[0] = 16'h5555;
        @(negedge clk);
        n_tests++;
        if (mem_save !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_access_save: save=%b expected 1", mem_save);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({mem_save, ack0, ack1, busy} !== 4'b0000 || rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_access_drop: save/ack0/ack1/busy=%b rdata0=%h rdata1=%h expected 0000/0000/0000",
                     {mem_save, ack0, ack1, busy}, rdata0, rdata1);
        end
        rst = 1'b0; rq = 2'b00; rwe = 2'b00;
        @(negedge clk);
        n_tests++;
        if (ack0 !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_access_after: ack0=%b busy=%b expected 0/0", ack0, busy);
        end
    endtask

    task automatic test_random();
        int          next_sample = 0;
        int          grant_cyc   = -10;
        int          n_acks      = 0;
        logic        g_id        = 1'b0;
        logic        g_we        = 1'b0;
        logic [15:0] g_addr      = 16'h0000;
        logic [15:0] g_wdata     = 16'h0000;
        logic [15:0] exp_rd [2];
        logic        w;
        logic        exp_ack0, exp_ack1, exp_busy, exp_save, locked, acked;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        logic        last = 1'b1;
`endif
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'($urandom);
            preload(16'(i), ref_mem[i]);
        end
        do_reset();
        exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0000;
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_ack0 = (cyc == grant_cyc + 2) && !g_id;
            exp_ack1 = (cyc == grant_cyc + 2) && g_id;
            exp_busy = (cyc == grant_cyc + 1) || (cyc == grant_cyc + 2);
            exp_save = (cyc == grant_cyc + 1) && g_we;
            n_tests++;
            if ({ack0, ack1, busy, mem_save} !== {exp_ack0, exp_ack1, exp_busy, exp_save}) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc=%0d: ack0/ack1/busy/save=%b expected %b", cyc,
                         {ack0, ack1, busy, mem_save}, {exp_ack0, exp_ack1, exp_busy, exp_save});
            end
            if (cyc > grant_cyc) begin
                n_tests++;
                if (mem_addr !== {1'b0, g_addr[15:1]} || mem_wdata !== g_wdata) begin
                    n_fail++;
                    $display("FAIL rand_bus cyc=%0d: addr=%h wdata=%h expected %h/%h", cyc,
                             mem_addr, mem_wdata, {1'b0, g_addr[15:1]}, g_wdata);
                end
            end
            n_tests++;
            if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
                n_fail++;
                $display("FAIL rand_rdata cyc=%0d: rdata0=%h rdata1=%h expected %h/%h", cyc,
                         rdata0, rdata1, exp_rd[0], exp_rd[1]);
            end
            if (cyc == grant_cyc + 2) begin
                n_acks++;
                if (!g_we) exp_rd[g_id] = ref_mem[g_addr[4:1]];
            end
            for (int r = 0; r < 2; r++) begin
                locked = (cyc == grant_cyc + 1) && (g_id == 1'(r));
                acked  = (cyc == grant_cyc + 2) && (g_id == 1'(r));
                if (!locked) begin
                    if (acked) begin
                        if ($urandom_range(0, 1) == 1) new_req(r);
                        else rq[r] = 1'b0;
                    end else if (rq[r]) begin
                        if ($urandom_range(0, 15) == 0) rq[r] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        new_req(r);
                    end
                end
            end
            if (cyc == next_sample) begin
                if (rq != 2'b00) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    w = (rq == 2'b11) ? ~last : rq[1];
                    last = w;
`else
                    w = (rq == 2'b11) ? 1'b0 : rq[1];
`endif
                    grant_cyc = cyc; g_id = w; g_we = rwe[w];
                    g_addr = raddr[w]; g_wdata = rwd[w];
                    if (g_we) ref_mem[g_addr[4:1]] = g_wdata;
                    next_sample = cyc + 3;
                end else begin
                    next_sample = cyc + 1;
                end
            end
            @(negedge clk);
        end
        rq = 2'b00;
        n_tests++;
        if (n_acks < 100) begin
            n_fail++;
            $display("FAIL rand_activity: acks=%0d expected at least 100", n_acks);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_simultaneous();
        test_held();
        test_reset_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data port of the word-addressed 16-bit memory between two requesters: the processor core (requester 0) and a loader/debug engine (requester 1). It runs a three-state sequencer (arbitrate, access, respond) and registers each winner's command before driving the memory. It returns read data and a one-cycle acknowledge to the winner only. It sits between the logic sector's memory address/data/write outputs and the memory data port, on the same clock as the memory's data side.

## Interface
Parameters:
- WIDTH, 16, data and byte-address width of every requester and memory bus

Ports:
- clk  in  1  rising-edge clock, same clock as the memory data port
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held high until the matching ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  in  WIDTH  byte address; stable while req is high
- wdata0 / wdata1  in  WIDTH  write data; stable while req is high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  WIDTH  read result, held until that requester's next read ack
- mem_addr  out  WIDTH  word address to memory
- mem_wdata  out  WIDTH  write data to memory
- mem_save  out  1  memory write strobe
- mem_rdata  in  WIDTH  memory read data, registered inside memory, valid one cycle after mem_addr
- busy  out  1  high whenever state is not IDLE

## Operation
- The sequencer has three states: IDLE, ACCESS and RESP.
- IDLE: req0 and req1 are sampled.
  - If neither is high, the sequencer stays in IDLE.
  - Otherwise a winner is chosen and its we, addr and wdata are latched into command registers, along with a 1-bit winner id. Next state is ACCESS.
- ACCESS:
  - mem_addr = {1'b0, cmd_addr[WIDTH-1:1]}; byte address bit 0 is ignored.
  - mem_wdata = cmd_wdata.
  - mem_save = cmd_we.
  - Next state is RESP.
- RESP:
  - ack of the winner is 1; the other ack is 0.
  - On a read, the winner's rdata is loaded with mem_rdata at the end of RESP.
  - On a write, rdata is unchanged.
  - Next state is always IDLE. Requests are not sampled in RESP.
- Outside ACCESS, mem_save = 0. mem_addr and mem_wdata still show the command registers.
- Priority without the macro: requester 0 always wins a simultaneous request.
- A requester that keeps req high after its ack is treated as issuing a new request at the next IDLE sample.
- A requester deasserting req while not yet granted is legal; that request is never serviced.
- Reset values:
  - State is IDLE.
  - All ack = 0, busy = 0, mem_save = 0.
  - mem_addr = 0, mem_wdata = 0.
  - rdata0 = rdata1 = 0.
  - Command registers = 0; last-winner register = 1.
- Reset mid-transaction: the in-flight access is dropped, with no ack and no rdata update. If reset is asserted during ACCESS, mem_save falls in the cycle after that edge.

## Timing
- Latency: req is sampled at edge N (IDLE). Cycle N+1 is ACCESS; cycle N+2 is RESP with ack high; the sequencer is back in IDLE at N+3.
- Throughput: at most one access per 3 cycles. Back-to-back alternating requesters yield one ack every 3 cycles.
- The ack pulse is exactly one cycle wide. rdata is valid from the cycle after ack onward.
- A requester that registers ack and clears req on the same edge produces no duplicate access.
- The memory's instruction port is unaffected. The block never stalls instruction fetch.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - When both requesters are high in IDLE, the requester that did not win the most recent grant wins.
  - The last-winner register updates on every grant.
  - After reset, requester 0 wins the first tie.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties. The last-winner register is not implemented.

## Test plan
- Single read: preload word 0x0012 = 0xBEEF. Raise req0 (we0=0, addr0=0x0024) at edge 0 → mem_addr=0x0012 in cycle 1, mem_save=0 throughout, ack0 in cycle 2, rdata0=0xBEEF afterwards, ack1 never high.
- Write then read: req1 writes wdata1=0x1234 to addr1=0x0041 → mem_save=1 only in the ACCESS cycle with mem_addr=0x0020. A following req0 read of 0x0040 returns rdata0=0x1234, and rdata1 stays at its prior value.
- Simultaneous requests: req0 and req1 high together, both kept high for 4 transactions → without the macro acks go 0,0,0,0; with MEM_ARB_ROUND_ROBIN_EN acks go 0,1,0,1.
- Held request: req0 kept high for 9 cycles starting at edge 0 → ack0 in cycles 2, 5 and 8, and busy low only in cycles 0, 3 and 6.
- Reset in ACCESS: rst pulsed during a write's ACCESS cycle → mem_save low in the following cycle, no ack, busy=0, rdata0=rdata1=0.
